scan_rx: RTL and testbench

//  Receive end of the multiplexed digit display bus. Watches the 5-bit symbol stream
//  (digits 100/010/001 each held one slot, separated by a decimal-point marker) and

---
 rtl/scan_pkg.sv | 60 ++++++
 rtl/scan_sym_dec.sv | 24 ++
 rtl/scan_rx.sv | 217 +++++++++++++++++++++
 tb/tb_scan_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the multiplexed digit display bus.
// The transmit and receive sides both use these symbol codes, the FSM state
// constants and the code/BCD helper functions.
package scan_pkg;

    // Symbol codes as they appear on the 5-bit display bus
    localparam logic [4:0] pZERO  = 5'b10001;
    localparam logic [4:0] pONE   = 5'b00001;
    localparam logic [4:0] pTWO   = 5'b00011;
    localparam logic [4:0] pTHREE = 5'b00010;
    localparam logic [4:0] pFOUR  = 5'b00110;
    localparam logic [4:0] pFIVE  = 5'b00100;
    localparam logic [4:0] pSIX   = 5'b01100;
    localparam logic [4:0] pSEVEN = 5'b01000;
    localparam logic [4:0] pEIGHT = 5'b11000;
    localparam logic [4:0] pNINE  = 5'b10000;
    localparam logic [4:0] pDP    = 5'b10101;
    localparam logic [4:0] pBLANK = 5'b00000;

    // Receiver FSM states
    localparam logic [1:0] S_HUNT = 2'd0;
    localparam logic [1:0] S_MARK = 2'd1;
    localparam logic [1:0] S_DIG  = 2'd2;
    localparam logic [1:0] S_CHK  = 2'd3;

    // Maps a bus code to {not_digit, bcd}. Every non-digit code (including
    // DP and BLANK) returns not_digit=1 and bcd=0; callers separate DP/BLANK.
    function automatic logic [4:0] f_code2bcd(input logic [4:0] code);
        logic [4:0] res;
        case (code)
            pZERO:   res = {1'b0, 4'd0};
            pONE:    res = {1'b0, 4'd1};
            pTWO:    res = {1'b0, 4'd2};
            pTHREE:  res = {1'b0, 4'd3};
            pFOUR:   res = {1'b0, 4'd4};
            pFIVE:   res = {1'b0, 4'd5};
            pSIX:    res = {1'b0, 4'd6};
            pSEVEN:  res = {1'b0, 4'd7};
            pEIGHT:  res = {1'b0, 4'd8};
            pNINE:   res = {1'b0, 4'd9};
            default: res = {1'b1, 4'd0};
        endcase
        return res;
    endfunction

    // Three BCD digits to binary using shift-add only (x100 = 64+32+4, x10 = 8+2).
    // Inputs are at most 9 each, so the result fits in 10 bits (max 999).
    function automatic logic [9:0] f_bcd2bin(input logic [3:0] d100,
                                             input logic [3:0] d010,
                                             input logic [3:0] d001);
        logic [9:0] h;
        logic [9:0] t;
        logic [9:0] u;
        h = {6'd0, d100};
        t = {6'd0, d010};
        u = {6'd0, d001};
        return (h << 6) + (h << 5) + (h << 2) + (t << 3) + (t << 1) + u;
    endfunction

endpackage

// File: rtl/scan_sym_dec.sv
// Combinational symbol classifier: splits a bus code into marker, blank,
// illegal and a BCD digit value.
module scan_sym_dec
    import scan_pkg::*;
(
    input  logic [4:0] code,
    output logic       is_dp,
    output logic       is_blank,
    output logic       illegal,
    output logic [3:0] bcd
);

    logic [4:0] dec_s;

    // Classify the current code; illegal means neither a digit, DP nor BLANK
    always_comb begin
        dec_s    = f_code2bcd(code);
        is_dp    = (code == pDP);
        is_blank = (code == pBLANK);
        illegal  = dec_s[4] & ~is_dp & ~is_blank;
        bcd      = dec_s[3:0];
    end

endmodule

// File: rtl/scan_rx.sv
// Receive end of the multiplexed digit display bus.
// Locks onto the DP marker, samples three digit slots mid-slot, confirms the
// closing marker and publishes the frame as BCD and binary.
module scan_rx
    import scan_pkg::*;
#(
    parameter int P_SLOT = 20001,
    parameter int P_MTO  = 40002
)(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_code,
    output logic [3:0] o_d100,
    output logic [3:0] o_d010,
    output logic [3:0] o_d001,
    output logic [9:0] o_bin,
    output logic       o_valid,
    output logic       o_err,
    output logic       o_locked
);

    localparam logic [15:0] C_HALF      = 16'(P_SLOT / 2);
    localparam logic [15:0] C_SLOT_LAST = 16'(P_SLOT - 1);
    localparam logic [15:0] C_MTO_LAST  = 16'(P_MTO - 1);

    logic       is_dp_s;
    logic       is_blank_s;
    logic       illegal_s;
    logic [3:0] bcd_s;
    logic       digit_s;
    logic       sample_s;
    logic [15:0] cnt_wrap_s;

    logic [1:0]  state_r, state_s;
    logic [15:0] cnt_r,   cnt_s;
    logic [1:0]  idx_r,   idx_s;
    logic [3:0]  sh100_r, sh100_s;
    logic [3:0]  sh010_r, sh010_s;
    logic [3:0]  sh001_r, sh001_s;
    logic        commit_r, commit_s;
    logic        err_s;

    logic [3:0]  d100_r;
    logic [3:0]  d010_r;
    logic [3:0]  d001_r;
    logic [9:0]  bin_r;
    logic        valid_r;
    logic        err_r;
    logic        locked_r;

    scan_sym_dec u_dec (
        .code     (i_code),
        .is_dp    (is_dp_s),
        .is_blank (is_blank_s),
        .illegal  (illegal_s),
        .bcd      (bcd_s)
    );

    // Slot timing helpers: digit test, mid-slot sample point, wrapping slot count
    always_comb begin
        digit_s  = ~is_dp_s & ~is_blank_s & ~illegal_s;
        sample_s = (cnt_r == C_HALF);
        if (cnt_r == C_SLOT_LAST) begin
            cnt_wrap_s = 16'd0;
        end else begin
            cnt_wrap_s = cnt_r + 16'd1;
        end
    end

    // Frame FSM next-state: marker hunt, marker timing, digit capture, closing check
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        idx_s    = idx_r;
        sh100_s  = sh100_r;
        sh010_s  = sh010_r;
        sh001_s  = sh001_r;
        commit_s = 1'b0;
        err_s    = 1'b0;
        case (state_r)
            S_HUNT: begin
                if (is_dp_s) begin
                    state_s = S_MARK;
                    cnt_s   = 16'd0;
                end else begin
                    state_s = S_HUNT;
                end
            end
            S_MARK: begin
                if (is_dp_s) begin
                    if (cnt_r == C_MTO_LAST) begin
                        err_s   = 1'b1;
                        state_s = S_HUNT;
                        cnt_s   = 16'd0;
                    end else begin
                        cnt_s = cnt_r + 16'd1;
                    end
                end else begin
                    // first cycle of the hundreds slot
                    state_s = S_DIG;
                    idx_s   = 2'd0;
                    cnt_s   = 16'd0;
                end
            end
            S_DIG: begin
                cnt_s = cnt_wrap_s;
                if (sample_s) begin
                    if (digit_s) begin
                        case (idx_r)
                            2'd0:    sh100_s = bcd_s;
                            2'd1:    sh010_s = bcd_s;
                            default: sh001_s = bcd_s;
                        endcase
                        if (idx_r == 2'd2) begin
                            state_s = S_CHK;
                            idx_s   = 2'd0;
                        end else begin
                            idx_s = idx_r + 2'd1;
                        end
                    end else if (is_dp_s) begin
                        // short frame: this marker may start the next frame
                        err_s   = 1'b1;
                        state_s = S_MARK;
                        cnt_s   = 16'd0;
                    end else begin
                        err_s   = 1'b1;
                        state_s = S_HUNT;
                        cnt_s   = 16'd0;
                    end
                end else begin
                    state_s = S_DIG;
                end
            end
            S_CHK: begin
                cnt_s = cnt_wrap_s;
                if (sample_s) begin
                    if (is_dp_s) begin
                        // sampled mid-marker, so the marker count starts half-way
                        commit_s = 1'b1;
                        state_s  = S_MARK;
                        cnt_s    = C_HALF;
                    end else begin
                        err_s   = 1'b1;
                        state_s = S_HUNT;
                        cnt_s   = 16'd0;
                    end
                end else begin
                    state_s = S_CHK;
                end
            end
            default: begin
                state_s = S_HUNT;
                cnt_s   = 16'd0;
                idx_s   = 2'd0;
            end
        endcase
    end

    // FSM, counter and shadow registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= S_HUNT;
            cnt_r    <= 16'd0;
            idx_r    <= 2'd0;
            sh100_r  <= 4'd0;
            sh010_r  <= 4'd0;
            sh001_r  <= 4'd0;
            commit_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            idx_r    <= idx_s;
            sh100_r  <= sh100_s;
            sh010_r  <= sh010_s;
            sh001_r  <= sh001_s;
            commit_r <= commit_s;
        end
    end

    // Output stage: digits on commit, binary and valid one cycle later, lock flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            d100_r   <= 4'd0;
            d010_r   <= 4'd0;
            d001_r   <= 4'd0;
            bin_r    <= 10'd0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
            locked_r <= 1'b0;
        end else begin
            if (commit_s) begin
                d100_r <= sh100_r;
                d010_r <= sh010_r;
                d001_r <= sh001_r;
            end
            if (commit_r) begin
                bin_r <= f_bcd2bin(d100_r, d010_r, d001_r);
            end
            valid_r <= commit_r;
            err_r   <= err_s;
            if (err_s) begin
                locked_r <= 1'b0;
            end else if (commit_r) begin
                locked_r <= 1'b1;
            end
        end
    end

    assign o_d100   = d100_r;
    assign o_d010   = d010_r;
    assign o_d001   = d001_r;
    assign o_bin    = bin_r;
    assign o_valid  = valid_r;
    assign o_err    = err_r;
    assign o_locked = locked_r;

endmodule

// File: tb/tb_scan_rx.sv
// Directed bench for scan_rx with a behavioural transmitter (16-cycle slots).
module tb_scan_rx;

    localparam logic [4:0] C_D0 = 5'b10001;
    localparam logic [4:0] C_D1 = 5'b00001;
    localparam logic [4:0] C_D2 = 5'b00011;
    localparam logic [4:0] C_D3 = 5'b00010;
    localparam logic [4:0] C_D4 = 5'b00110;
    localparam logic [4:0] C_D5 = 5'b00100;
    localparam logic [4:0] C_D6 = 5'b01100;
    localparam logic [4:0] C_D7 = 5'b01000;
    localparam logic [4:0] C_D8 = 5'b11000;
    localparam logic [4:0] C_D9 = 5'b10000;
    localparam logic [4:0] C_DP = 5'b10101;
    localparam logic [4:0] C_BL = 5'b00000;
    localparam logic [4:0] C_BAD = 5'b11111;

    logic       i_clk;
    logic       i_rst;
    logic [4:0] i_code;
    logic [3:0] o_d100;
    logic [3:0] o_d010;
    logic [3:0] o_d001;
    logic [9:0] o_bin;
    logic       o_valid;
    logic       o_err;
    logic       o_locked;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_valid = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         err_cyc = 0;
    logic       both_seen = 1'b0;
    logic [9:0] last_bin = 10'd0;

    scan_rx #(.P_SLOT(16), .P_MTO(32)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_code   (i_code),
        .o_d100   (o_d100),
        .o_d010   (o_d010),
        .o_d001   (o_d001),
        .o_bin    (o_bin),
        .o_valid  (o_valid),
        .o_err    (o_err),
        .o_locked (o_locked)
    );

    always #5 i_clk = ~i_clk;

    // one clock, observed 1 time unit after the edge; tallies output pulses
    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
        if (o_valid) begin
            n_valid++;
            last_bin = o_bin;
        end
        if (o_err) begin
            n_err++;
            if (err_cyc == 0) err_cyc = cyc;
        end
        if (o_valid && o_err) both_seen = 1'b1;
    endtask

    task automatic hold(input logic [4:0] c, input int n);
        i_code = c;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sym(input logic [4:0] c);
        hold(c, 16);
    endtask

    task automatic clr();
        n_valid = 0;
        n_err   = 0;
        err_cyc = 0;
        cyc     = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        i_clk  = 1'b0;
        i_rst  = 1'b1;
        i_code = C_BL;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_bin", 32'(o_bin), 32'd0);
        chk("rst_d100", 32'(o_d100), 32'd0);
        chk("rst_locked", 32'(o_locked), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        i_rst = 1'b0;
        hold(C_BL, 4);

        // 1: two frames of 456
        clr();
        sym(C_DP); sym(C_D4); sym(C_D5); sym(C_D6); sym(C_DP);
        sym(C_D4); sym(C_D5); sym(C_D6); sym(C_DP);
        chk("t1_nvalid", 32'(n_valid), 32'd2);
        chk("t1_nerr", 32'(n_err), 32'd0);
        chk("t1_bin", 32'(last_bin), 32'd456);
        chk("t1_d100", 32'(o_d100), 32'd4);
        chk("t1_d010", 32'(o_d010), 32'd5);
        chk("t1_d001", 32'(o_d001), 32'd6);
        chk("t1_locked", 32'(o_locked), 32'd1);

        // 2: repeated digits 999, then 000
        clr();
        sym(C_D9); sym(C_D9); sym(C_D9); sym(C_DP);
        chk("t2_nvalid999", 32'(n_valid), 32'd1);
        chk("t2_bin999", 32'(last_bin), 32'd999);
        clr();
        sym(C_D0); sym(C_D0); sym(C_D0); sym(C_DP);
        chk("t2_nvalid000", 32'(n_valid), 32'd1);
        chk("t2_bin000", 32'(o_bin), 32'd0);
        chk("t2_d100", 32'(o_d100), 32'd0);
        chk("t2_d001", 32'(o_d001), 32'd0);

        // 3: frame without leading marker after reset is ignored
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        clr();
        sym(C_D1); sym(C_D2); sym(C_D3); sym(C_DP);
        sym(C_D7); sym(C_D8); sym(C_D9); sym(C_DP);
        chk("t3_nvalid", 32'(n_valid), 32'd1);
        chk("t3_bin", 32'(last_bin), 32'd789);
        chk("t3_nerr", 32'(n_err), 32'd0);

        // 4: illegal tens code after a good 456
        sym(C_D4); sym(C_D5); sym(C_D6); sym(C_DP);
        chk("t4_pre_bin", 32'(o_bin), 32'd456);
        clr();
        sym(C_D1); sym(C_BAD); sym(C_D3);
        chk("t4_nerr", 32'(n_err), 32'd1);
        chk("t4_nvalid", 32'(n_valid), 32'd0);
        chk("t4_hold_bin", 32'(o_bin), 32'd456);
        chk("t4_hold_d010", 32'(o_d010), 32'd5);
        chk("t4_locked", 32'(o_locked), 32'd0);
        clr();
        sym(C_DP); sym(C_D1); sym(C_D2); sym(C_D3); sym(C_DP);
        chk("t4_nvalid_123", 32'(n_valid), 32'd1);
        chk("t4_bin_123", 32'(last_bin), 32'd123);
        chk("t4_relock", 32'(o_locked), 32'd1);

        // 5: marker held 40 cycles from HUNT; the first DP edge enters MARK
        // with cnt=0, so the timeout pulse appears after the 33rd edge
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        hold(C_BL, 4);
        clr();
        hold(C_DP, 40);
        chk("t5_nerr", 32'(n_err), 32'd1);
        chk("t5_err_cycle", 32'(err_cyc), 32'd33);
        chk("t5_locked", 32'(o_locked), 32'd0);
        sym(C_D3); sym(C_D2); sym(C_D1); sym(C_DP);
        chk("t5_nvalid", 32'(n_valid), 32'd1);
        chk("t5_bin", 32'(last_bin), 32'd321);
        chk("t5_relock", 32'(o_locked), 32'd1);

        // 6: reset in the middle of a digit slot
        clr();
        sym(C_D4);
        hold(C_D5, 5);
        i_rst = 1'b1;
        tick();
        chk("t6_bin", 32'(o_bin), 32'd0);
        chk("t6_d100", 32'(o_d100), 32'd0);
        chk("t6_locked", 32'(o_locked), 32'd0);
        i_rst = 1'b0;
        hold(C_D5, 11);
        sym(C_D6);
        sym(C_DP); sym(C_D7); sym(C_D0); sym(C_D5); sym(C_DP);
        chk("t6_nvalid", 32'(n_valid), 32'd1);
        chk("t6_nerr", 32'(n_err), 32'd0);
        chk("t6_bin", 32'(last_bin), 32'd705);
        chk("t6_d001", 32'(o_d001), 32'd5);

        chk("valid_err_exclusive", 32'(both_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
